prbs9_seq_ctrl: RTL

- Sequencer for the PRBS9 pattern generators of the TX test path (I and Q branches share its outputs).
- On start, it seeds the generators with a one-cycle reset pulse.
- It then issues one-cycle enable strobes at symbol rate (one per OS clocks) and counts emitted symbols.
- It stops after a programmed symbol count, or on request, and flags completion to the BER/test logic.

---
 rtl/prbs9_seq_ctrl_pkg.sv | 15 +
 rtl/prbs9_seq_ctrl_symbol_tick.sv | 27 ++
 rtl/prbs9_seq_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/prbs9_seq_ctrl_pkg.sv
// Shared definitions for the PRBS9 sequencer: state encoding and default sizing
// reused by the TX top and the BER checker.
package prbs9_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int OS_DEFAULT     = 4;
  localparam int NSYM_W_DEFAULT = 16;

endpackage

// File: rtl/prbs9_seq_ctrl_symbol_tick.sv
// Symbol-rate phase counter: counts 0..OS-1 while run is high and flags the
// last phase. With OS=1 the phase register stays at 0 and tick follows run.
module symbol_tick #(
  parameter int OS = 4
) (
  input  logic clock,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int PW = (OS > 1) ? $clog2(OS) : 1;
  localparam logic [PW-1:0] LAST = PW'(OS - 1);

  logic [PW-1:0] phase_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      phase_q <= '0;
    end else if (run) begin
      phase_q <= (phase_q == LAST) ? '0 : phase_q + PW'(1);
    end
  end

  assign tick = run && (phase_q == LAST);

endmodule

// File: rtl/prbs9_seq_ctrl.sv
// PRBS9 sequencer: seeds the generators, strobes enable once per OS clocks,
// counts symbols and pulses o_done when the programmed count or a stop ends the run.
module prbs9_seq_ctrl
  import prbs9_seq_ctrl_pkg::*;
#(
  parameter int OS     = OS_DEFAULT,
  parameter int NSYM_W = NSYM_W_DEFAULT
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [NSYM_W-1:0] i_nsym,
  output logic              o_prbs_reset,
  output logic              o_prbs_enable,
  output logic              o_busy,
  output logic              o_done,
  output logic [NSYM_W-1:0] o_sym_count,
  output logic [1:0]        state_dbg
);

  // Handshake: i_start/i_stop are level requests sampled only in the state
  // that honours them (IDLE / RUN); all outputs are Moore on registered state.

  state_t            state_q, state_d;
  logic [NSYM_W-1:0] nsym_q;
  logic [NSYM_W-1:0] count_q;
  logic [NSYM_W-1:0] count_inc;
  logic              tick;
  logic              last_sym;

  symbol_tick #(.OS(OS)) u_tick (
    .clock (clock),
    .clear (i_reset || (state_q == ST_SEED)),
    .run   (state_q == ST_RUN),
    .tick  (tick)
  );

  assign count_inc = count_q + NSYM_W'(1);
  // nsym=0 means free-run, so only a non-zero request can terminate the run.
  assign last_sym  = (nsym_q != '0) && (count_inc == nsym_q);

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      nsym_q  <= '0;
      count_q <= '0;
    end else begin
      if ((state_q == ST_IDLE) && i_start) begin
        nsym_q <= i_nsym;
      end
      if (state_q == ST_SEED) begin
        count_q <= '0;
      end else if (tick) begin
        count_q <= count_inc;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    o_prbs_reset  = 1'b0;
    o_prbs_enable = 1'b0;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_SEED;
      end
      ST_SEED: begin
        o_prbs_reset = 1'b1;
        o_busy       = 1'b1;
        state_d      = ST_RUN;
      end
      ST_RUN: begin
        o_busy        = 1'b1;
        o_prbs_enable = tick;
        if ((tick && last_sym) || i_stop) state_d = ST_DONE;
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_sym_count = count_q;
  assign state_dbg   = state_q;

endmodule
